// File: rtl/feature_stage_acc_if.sv
// Generic valid/ready/data channel used by every port of feature_stage_acc.
// The master drives valid and data; the slave drives ready.
interface feature_stage_acc_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/feature_stage_acc.sv
// Weak-classifier leaf select and stage accumulate for the cascade classifier.
// Joins feature sum, feature threshold and leaf pair; emits one pass/fail token per stage.
module feature_stage_acc #(
  parameter int W_FEAT = 20,
  parameter int W_THR  = 16,
  parameter int W_LEAF = 16,
  parameter int W_ACC  = 24,
  parameter int W_CNT  = 8
) (
  input  logic                clk,
  input  logic                rst,
  feature_stage_acc_if.slave  feat_if,
  feature_stage_acc_if.slave  thr_if,
  feature_stage_acc_if.slave  leaf_if,
  feature_stage_acc_if.slave  stage_thr_if,
  feature_stage_acc_if.master stage_if
);

  typedef enum logic [1:0] {
    ACC = 2'd0,
    CMP = 2'd1,
    OUT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [W_FEAT-1:0] feat_sum_p0;
  logic                     feat_last_p0;
  logic signed [W_THR-1:0]  thr_p0;
  logic signed [W_LEAF-1:0] left_p0;
  logic signed [W_LEAF-1:0] right_p0;
  logic signed [W_ACC-1:0]  stage_thr_p0;
  logic                     vld_p0;

  logic signed [W_ACC-1:0]  acc_p1;
  logic        [W_CNT-1:0]  cnt_p1;
  logic                     pass_p1;

  // Left leaf when the feature is strictly below its threshold; ties go right.
  function automatic logic signed [W_LEAF-1:0] select_leaf(
    input logic signed [W_FEAT-1:0] feat,
    input logic signed [W_THR-1:0]  thr,
    input logic signed [W_LEAF-1:0] left,
    input logic signed [W_LEAF-1:0] right
  );
    logic signed [W_FEAT-1:0] thr_ext;
    thr_ext = W_FEAT'(thr);
    return (feat < thr_ext) ? left : right;
  endfunction

  // Two's-complement wrap; the stage sum never saturates.
  function automatic logic signed [W_ACC-1:0] wrap_add(
    input logic signed [W_ACC-1:0]  acc,
    input logic signed [W_LEAF-1:0] leaf
  );
    logic signed [W_ACC-1:0] leaf_ext;
    leaf_ext = W_ACC'(leaf);
    return acc + leaf_ext;
  endfunction

  // p0: unpack the joined inputs
  assign feat_sum_p0  = feat_if.data[W_FEAT-1:0];
  assign feat_last_p0 = feat_if.data[W_FEAT];
  assign thr_p0       = thr_if.data;
  assign left_p0      = leaf_if.data[W_LEAF-1:0];
  assign right_p0     = leaf_if.data[2*W_LEAF-1:W_LEAF];
  assign stage_thr_p0 = stage_thr_if.data;
  assign vld_p0       = feat_if.valid & thr_if.valid & leaf_if.valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (vld_p0 && feat_last_p0) state_d = CMP;
      CMP:     if (stage_thr_if.valid)     state_d = OUT;
      OUT:     if (stage_if.ready)         state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // The three feature-side readys rise together so no channel is consumed alone.
  always_comb begin
    feat_if.ready      = 1'b0;
    thr_if.ready       = 1'b0;
    leaf_if.ready      = 1'b0;
    stage_thr_if.ready = 1'b0;
    stage_if.valid     = 1'b0;
    unique case (state_q)
      ACC: begin
        feat_if.ready = vld_p0;
        thr_if.ready  = vld_p0;
        leaf_if.ready = vld_p0;
      end
      CMP:     stage_thr_if.ready = 1'b1;
      OUT:     stage_if.valid     = 1'b1;
      default: ;
    endcase
  end

  // p1: stage accumulator, feature count and registered verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1  <= '0;
      cnt_p1  <= '0;
      pass_p1 <= 1'b0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (vld_p0) begin
            acc_p1 <= wrap_add(acc_p1, select_leaf(feat_sum_p0, thr_p0, left_p0, right_p0));
            cnt_p1 <= cnt_p1 + W_CNT'(1);
          end
        end
        CMP: begin
          if (stage_thr_if.valid) pass_p1 <= (acc_p1 >= stage_thr_p0);
        end
        OUT: begin
          if (stage_if.ready) begin
            acc_p1 <= '0;
            cnt_p1 <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stage_if.data = {pass_p1, cnt_p1};

endmodule

// File: tb/tb_feature_stage_acc.sv
// Directed bench for feature_stage_acc: default-width instance plus a narrow
// instance (W_ACC=8, W_CNT=2) for the wrap-around cases.
module tb_feature_stage_acc;

  typedef struct {
    int f;
    int t;
    int l;
    int r;
    bit last;
  } tok_t;

  typedef struct {
    bit     pass;
    int     n;
    longint acc;
  } exp_t;

  logic clk;
  logic rst;

  logic        fv[2], tv[2], lv[2], sv[2], ordy[2];
  logic [20:0] fdata[2];
  logic [15:0] tdata[2];
  logic [31:0] ldata[2];
  logic [23:0] sdata[2];

  logic       frdy[2], trdy[2], lrdy[2], srdy[2], ovld[2], opass[2];
  logic [7:0] ocnt[2];

  bit         held[2];
  bit         hpass[2];
  logic [7:0] hcnt[2];

  exp_t expq0[$];
  exp_t expq1[$];

  int vectors;
  int miscompares;

  feature_stage_acc_if #(21) feat0 ();
  feature_stage_acc_if #(16) thr0 ();
  feature_stage_acc_if #(32) leaf0 ();
  feature_stage_acc_if #(24) sthr0 ();
  feature_stage_acc_if #(9)  st0 ();
  feature_stage_acc_if #(21) feat1 ();
  feature_stage_acc_if #(16) thr1 ();
  feature_stage_acc_if #(32) leaf1 ();
  feature_stage_acc_if #(8)  sthr1 ();
  feature_stage_acc_if #(3)  st1 ();

  assign feat0.valid = fv[0];  assign feat0.data = fdata[0];
  assign thr0.valid  = tv[0];  assign thr0.data  = tdata[0];
  assign leaf0.valid = lv[0];  assign leaf0.data = ldata[0];
  assign sthr0.valid = sv[0];  assign sthr0.data = sdata[0];
  assign st0.ready   = ordy[0];
  assign feat1.valid = fv[1];  assign feat1.data = fdata[1];
  assign thr1.valid  = tv[1];  assign thr1.data  = tdata[1];
  assign leaf1.valid = lv[1];  assign leaf1.data = ldata[1];
  assign sthr1.valid = sv[1];  assign sthr1.data = sdata[1][7:0];
  assign st1.ready   = ordy[1];

  assign frdy[0] = feat0.ready;  assign frdy[1] = feat1.ready;
  assign trdy[0] = thr0.ready;   assign trdy[1] = thr1.ready;
  assign lrdy[0] = leaf0.ready;  assign lrdy[1] = leaf1.ready;
  assign srdy[0] = sthr0.ready;  assign srdy[1] = sthr1.ready;
  assign ovld[0] = st0.valid;    assign ovld[1] = st1.valid;
  assign opass[0] = st0.data[8]; assign opass[1] = st1.data[2];
  assign ocnt[0] = st0.data[7:0];
  assign ocnt[1] = {6'b0, st1.data[1:0]};

  feature_stage_acc dut0 (
    .clk(clk), .rst(rst),
    .feat_if(feat0), .thr_if(thr0), .leaf_if(leaf0),
    .stage_thr_if(sthr0), .stage_if(st0)
  );

  feature_stage_acc #(.W_ACC(8), .W_CNT(2)) dut1 (
    .clk(clk), .rst(rst),
    .feat_if(feat1), .thr_if(thr1), .leaf_if(leaf1),
    .stage_thr_if(sthr1), .stage_if(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tok_t mk(input int f, input int t, input int l, input int r, input bit last);
    tok_t k;
    k.f = f; k.t = t; k.l = l; k.r = r; k.last = last;
    return k;
  endfunction

  // Stage result from first principles: pick leaves, sum as integers, wrap to W_ACC.
  function automatic exp_t model(input tok_t q[$], input int sthr, input int wacc, input int wcnt);
    exp_t   e;
    longint sum;
    longint m;
    longint a;
    sum = 0;
    foreach (q[i]) sum += (q[i].f < q[i].t) ? q[i].l : q[i].r;
    m = longint'(1) << wacc;
    a = sum % m;
    if (a < 0) a += m;
    if (a >= m / 2) a -= m;
    e.acc  = a;
    e.pass = (a >= sthr);
    e.n    = q.size() % (1 << wcnt);
    return e;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Per-cycle comparison against the model queue and the channel rules.
  task automatic monitor();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        held[d] = 1'b0;
      end else begin
        check("ready_join_equal", {frdy[d], frdy[d]}, {trdy[d], lrdy[d]});
        if (frdy[d]) check("ready_needs_all_valid", {fv[d], tv[d], lv[d]}, 3'b111);
        if (held[d]) begin
          check("out_hold_valid", ovld[d], 1);
          check("out_hold_pass", opass[d], hpass[d]);
          check("out_hold_cnt", ocnt[d], hcnt[d]);
        end
        held[d] = 1'b0;
        if (ovld[d]) begin
          if (ordy[d]) begin
            if ((d == 0 ? expq0.size() : expq1.size()) == 0) begin
              check("unexpected_stage_token", ovld[d], 0);
            end else begin
              e = (d == 0) ? expq0.pop_front() : expq1.pop_front();
              check("model_pass", opass[d], e.pass);
              check("model_n_feat", ocnt[d], e.n);
            end
          end else begin
            held[d]  = 1'b1;
            hpass[d] = opass[d];
            hcnt[d]  = ocnt[d];
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    monitor();
  endtask

  task automatic feed(input int d, input tok_t q[$], input bit rnd, output bit ok);
    ok = 1'b1;
    foreach (q[i]) begin
      bit done;
      int guard;
      done  = 1'b0;
      guard = 0;
      while (!done) begin
        fdata[d] = {q[i].last, 20'(q[i].f)};
        tdata[d] = 16'(q[i].t);
        ldata[d] = {16'(q[i].r), 16'(q[i].l)};
        fv[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tv[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        lv[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        samp();
        check("acc_ready_tracks_valids", frdy[d], fv[d] & tv[d] & lv[d]);
        check("stage_thr_held_off", srdy[d], 0);
        done = frdy[d] & fv[d] & tv[d] & lv[d];
        tick();
        guard++;
        if (!done && guard > 200) begin
          check("feed_timeout", guard, 0);
          ok = 1'b0;
          fv[d] = 1'b0; tv[d] = 1'b0; lv[d] = 1'b0;
          return;
        end
      end
    end
    fv[d] = 1'b0; tv[d] = 1'b0; lv[d] = 1'b0;
  endtask

  // Runs one full stage; xp/xn are the hand-computed result for this stage.
  task automatic do_stage(input int d, input tok_t q[$], input int sthr, input bit rnd,
                          input int hold, input bit xp, input int xn);
    exp_t e;
    bit   ok;
    e = model(q, sthr, (d == 0) ? 24 : 8, (d == 0) ? 8 : 2);
    if (d == 0) expq0.push_back(e); else expq1.push_back(e);
    sv[d]    = 1'b1;
    sdata[d] = 24'(sthr);
    feed(d, q, rnd, ok);
    if (!ok) begin
      sv[d] = 1'b0;
      return;
    end
    ordy[d] = (hold == 0);
    if (hold > 0) begin
      fdata[d] = '0; tdata[d] = '0; ldata[d] = '0;
      fv[d] = 1'b1; tv[d] = 1'b1; lv[d] = 1'b1;
    end
    samp();
    check("cmp_stage_thr_ready", srdy[d], 1);
    check("cmp_no_output", ovld[d], 0);
    tick();
    sv[d] = 1'b0;
    samp();
    check("out_valid_t2", ovld[d], 1);
    check("out_pass_t2", opass[d], xp);
    check("out_n_feat_t2", ocnt[d], xn);
    for (int k = 0; k < hold; k++) begin
      check("hold_no_feature_accept", frdy[d], 0);
      check("hold_no_thr_accept", srdy[d], 0);
      check("hold_out_valid", ovld[d], 1);
      tick();
      if (k == hold - 1) begin
        fv[d] = 1'b0; tv[d] = 1'b0; lv[d] = 1'b0;
        ordy[d] = 1'b1;
      end
      samp();
    end
    tick();
  endtask

  initial begin
    tok_t s1[$];
    tok_t s1_part[$];
    tok_t sa[$];
    tok_t s5[$];
    exp_t e;
    bit   ok;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      fv[d] = 1'b0; tv[d] = 1'b0; lv[d] = 1'b0; sv[d] = 1'b0; ordy[d] = 1'b1;
      fdata[d] = '0; tdata[d] = '0; ldata[d] = '0; sdata[d] = '0;
      held[d] = 1'b0; hpass[d] = 1'b0; hcnt[d] = '0;
    end

    s1.push_back(mk(-5, 0, -2, 7, 1'b0));
    s1.push_back(mk(10, 10, 4, 9, 1'b0));
    s1.push_back(mk(3, 4, 6, 1, 1'b1));
    s1_part.push_back(s1[0]);
    s1_part.push_back(s1[1]);
    sa.push_back(mk(1, 2, 5, -3, 1'b1));
    for (int i = 0; i < 5; i++) s5.push_back(mk(0, 1, 26, -1, i == 4));

    // Pin the model with hand-computed values.
    e = model(s1, 0, 24, 8);
    check("model_s1_acc", e.acc, 13);
    check("model_s1_pass", e.pass, 1);
    check("model_s1_n", e.n, 3);
    e = model(s1, 14, 24, 8);
    check("model_s1_thr14_pass", e.pass, 0);
    e = model(s5, 0, 8, 2);
    check("model_wrap_acc", e.acc, -126);
    check("model_wrap_n", e.n, 1);

    tick();
    tick();
    rst = 1'b0;
    samp();
    for (int d = 0; d < 2; d++) begin
      check("reset_feat_ready", frdy[d], 0);
      check("reset_stage_thr_ready", srdy[d], 0);
      check("reset_out_valid", ovld[d], 0);
      check("reset_out_pass", opass[d], 0);
      check("reset_out_cnt", ocnt[d], 0);
    end
    tick();

    // Below-threshold stage, then the same stream failing the stage threshold.
    do_stage(0, s1, 0, 1'b0, 0, 1'b1, 3);
    do_stage(0, s1, 14, 1'b0, 0, 1'b0, 3);

    // Random valid gaps on each input channel, then 5 cycles of output backpressure.
    do_stage(0, s1, 0, 1'b1, 5, 1'b1, 3);

    // Back-to-back single-feature stages; the second shows acc was cleared.
    do_stage(0, sa, 5, 1'b0, 0, 1'b1, 1);
    do_stage(0, sa, 6, 1'b0, 0, 1'b0, 1);

    // Accumulator and counter wrap on the narrow instance.
    do_stage(1, s5, 0, 1'b0, 0, 1'b0, 1);

    // Reset after two of three features, then replay the full stage.
    feed(0, s1_part, 1'b0, ok);
    rst = 1'b1;
    samp();
    tick();
    rst = 1'b0;
    samp();
    for (int d = 0; d < 2; d++) begin
      check("midreset_feat_ready", frdy[d], 0);
      check("midreset_stage_thr_ready", srdy[d], 0);
      check("midreset_out_valid", ovld[d], 0);
    end
    tick();
    do_stage(0, s1, 0, 1'b0, 0, 1'b1, 3);

    check("stage_tokens_left_dut0", expq0.size(), 0);
    check("stage_tokens_left_dut1", expq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/feature_stage_acc.md
# feature_stage_acc

Downstream consumer of the feature-threshold ROM read port in the cascade classifier datapath. Per weak classifier, it joins the normalised feature sum, the feature threshold and the left/right leaf values, then selects a leaf and accumulates it into the stage sum. On the last feature of a stage, it compares the sum against the stage threshold and emits one pass/fail token per stage to the cascade control.

## Interface
Parameters:
- W_FEAT, 20: width of signed feature sum.
- W_THR, 16: width of signed feature threshold. W_THR ≤ W_FEAT; sign-extended for the compare.
- W_LEAF, 16: width of each signed leaf value.
- W_ACC, 24: width of signed stage accumulator and stage threshold.
- W_CNT, 8: width of the per-stage feature counter.

Ports (all dti: valid/ready/data):
- clk, input, 1: clock. One clock domain.
- rst, input, 1: reset. Synchronous, active-high.
- feat_if, dti.consumer, 1+W_FEAT: data = {last, feature_sum}. `last` marks the stage's final feature.
- thr_if, dti.consumer, W_THR: feature threshold from the threshold ROM read port.
- leaf_if, dti.consumer, 2*W_LEAF: data = {right_val, left_val}.
- stage_thr_if, dti.consumer, W_ACC: stage threshold.
- stage_if, dti.producer, 1+W_CNT: data = {pass, n_feat}. `n_feat` is the number of features accumulated in the stage.

## Operation
FSM states are ACC, CMP and OUT. Reset enters ACC with acc=0 and cnt=0.

ACC state:
- The three consumer inputs are joined.
- feat_if.ready, thr_if.ready and leaf_if.ready are all 1 iff feat_if.valid & thr_if.valid & leaf_if.valid. Otherwise all three are 0, so no partial consumption.
- On the joint handshake:
  - Compare feature_sum < sext(threshold), signed. True selects left_val; false, including equality, selects right_val.
  - acc ← acc + sext(selected), modulo 2^W_ACC, no saturation.
  - cnt ← cnt + 1, modulo 2^W_CNT.
  - If last=1, the next state is CMP.
- stage_thr_if.ready = 0. stage_if.valid = 0.

CMP state:
- Input readys are 0. stage_thr_if.ready = 1.
- On a handshake, register pass ← (acc ≥ stage_thr), signed, and go to OUT.

OUT state:
- stage_if.valid = 1 and data = {pass, cnt}. Data is stable while valid && !ready.
- On a handshake: acc ← 0, cnt ← 0, next state ACC.

Other rules:
- stage_thr_if tokens arriving early are held off (ready=0) until CMP. They are never dropped or buffered.
- A single-feature stage (last=1 on the first token) is legal.
- An n_feat value of 0 is only possible via wrap after 2^W_CNT features. This is legal and not flagged.
- rst asserted in any state forces ACC, acc=0, cnt=0, stage_if.valid=0 and all readys low in the next cycle. Partial stage contents are discarded.

## Timing
- Throughput is one weak classifier per cycle in ACC when all three inputs are valid every cycle.
- acc and cnt update on the clock edge after the joint handshake.
- Suppose the last feature handshake occurs at cycle t:
  - CMP is active at t+1; stage_thr_if.ready=1 from t+1.
  - If stage_thr_if is valid at t+1, stage_if.valid=1 at t+2.
  - With stage_if.ready=1 at t+2, ACC resumes and accepts the next feature at t+3.
- Minimum stage overhead is 2 cycles beyond the feature count.
- Readys in ACC depend combinationally on the three input valids only, never on the data.
- stage_if.valid and stage_if.data come from registers (state and pass/cnt), with no combinational path from inputs.
- Values after reset: all readys 0 until valids are seen in ACC; stage_if.valid=0; stage_if.data={0,0}.

## Test plan
1. **3-feature stage, below-threshold features.** Features (−5, 10, 3), thresholds (0, 10, 4), leaves {r,l} = {7,−2}, {9,4}, {1,6}, stage_thr=0.
   - Selections: left, right (equality), left, giving acc = −2 + 9 + 6 = 13.
   - Expected stage_if = {1, 3} at t+2 after the last handshake.
2. **Fail case.** Same feature/leaf stream, stage_thr=14 → expected stage_if = {0, 3}.
3. **Join and backpressure.**
   - Randomly deassert each of the three input valids: no token is consumed unless all three are valid, and the accumulated result matches scenario 1.
   - Hold stage_if.ready=0 for 5 cycles: valid and data stay stable and no inputs are accepted.
4. **Early stage threshold and back-to-back stages.**
   - stage_thr_if is valid from cycle 0: ready stays low until CMP.
   - Run two single-feature stages: feature 1 < thr 2 with leaves {−3,5} gives acc 5; with stage_thr values 5 and 6 the outputs are {1,1} then {0,1}.
   - acc is cleared between the stages.
5. **Wrap-around.**
   - W_ACC=8: leaves summing to 130 wrap to −126; with stage_thr=0 the output is {0, n}.
   - W_CNT=2 with 5 features → n_feat=1.
6. **Reset mid-stage.**
   - Assert rst after 2 of 3 features: the next cycle shows ACC state, all outputs low and acc=0.
   - Replaying scenario 1 afterwards yields {1,3}.
